t07_spitft_rx: RTL and testbench



---
 rtl/t07_spi_pkg.sv | 17 +
 rtl/t07_spi_sync.sv | 34 +++
 rtl/t07_spitft_rx.sv | 170 +++++++++++++++++
 tb/tb_t07_spitft_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/t07_spi_pkg.sv
// Shared definitions for the team 07 TFT SPI link (transmitter and receiver).
// Holds the frame field widths and the receiver state encoding.
package t07_spi_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int FRAME_BITS = ADDR_W_DEF + DATA_W_DEF;

  typedef enum logic [2:0] {
    LOCKOUT = 3'd0,
    IDLE    = 3'd1,
    SHIFT   = 3'd2,
    DONE    = 3'd3,
    WAIT_CS = 3'd4
  } rx_state_t;

endpackage

// File: rtl/t07_spi_sync.sv
// Two-flop synchroniser followed by a history flop, giving a level plus
// single-cycle rise/fall strobes in the clk domain.
module t07_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;
  logic hist_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_reg   <= RST_VAL;
      s2_reg   <= RST_VAL;
      hist_reg <= RST_VAL;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      hist_reg <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~hist_reg;
  assign fall  = ~s2_reg & hist_reg;

endmodule

// File: rtl/t07_spitft_rx.sv
// Responder end of the t07 TFT SPI write link: deserialises address+data
// frames and presents them on a one-entry valid/ready buffer.
module t07_spitft_rx
  import t07_spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              chipSelect,
  input  logic              sclk,
  input  logic              bitData,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              frameErr,
  output logic              overrun
);

  localparam int FB = ADDR_W + DATA_W;
  localparam int CW = $clog2(FB) + 1;
  localparam logic [2:0] SYNC_INIT = 3'b001;

  logic [2:0] raw_in;
  logic [2:0] lvl;
  logic [2:0] rse;
  logic [2:0] fll;
  logic       cs_level;
  logic       sclk_rise;
  logic       bit_level;
  logic       unused_edges;

  rx_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [FB-1:0] shift_reg, shift_next;
  logic [1:0]    settle_reg;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic valid_reg, valid_next;
  logic ferr_reg, ferr_next;
  logic overrun_reg, overrun_next;
  logic take;

  assign raw_in = {bitData, sclk, chipSelect};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    t07_spi_sync #(
      .RST_VAL(SYNC_INIT[gi])
    ) u_sync (
      .clk  (clk),
      .nrst (nrst),
      .din  (raw_in[gi]),
      .level(lvl[gi]),
      .rise (rse[gi]),
      .fall (fll[gi])
    );
  end

  assign cs_level     = lvl[0];
  assign sclk_rise    = rse[1];
  assign bit_level    = lvl[2];
  assign unused_edges = ^{rse[2], rse[0], fll};

  // The synchroniser reset values are not real samples; LOCKOUT only trusts
  // chipSelect once two genuine samples have reached the output stage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      settle_reg <= 2'b00;
    end else begin
      settle_reg <= {settle_reg[0], 1'b1};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    ferr_next  = 1'b0;
    case (state_reg)
      LOCKOUT: begin
        if (settle_reg[1] && cs_level) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (!cs_level) begin
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_level) begin
          ferr_next  = (cnt_reg != '0);
          state_next = IDLE;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[FB-2:0], bit_level};
          cnt_next   = cnt_reg + CW'(1);
          if (cnt_reg == CW'(FB - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = WAIT_CS;
      end
      WAIT_CS: begin
        if (cs_level) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = LOCKOUT;
      end
    endcase
  end

  // A consumer handshake in the DONE cycle frees the slot for the new frame.
  assign take = valid_reg && ready;

  always_comb begin
    address_next = address_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (state_reg == DONE) begin
      if (!valid_reg || take) begin
        address_next = shift_reg[FB-1 -: ADDR_W];
        data_next    = shift_reg[DATA_W-1:0];
        valid_next   = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (take) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= LOCKOUT;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      address_reg <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      address_reg <= address_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
      overrun_reg <= overrun_next;
    end
  end

  assign address  = address_reg;
  assign data     = data_reg;
  assign valid    = valid_reg;
  assign frameErr = ferr_reg;
  assign overrun  = overrun_reg;
  assign busy     = (state_reg == SHIFT) || (state_reg == DONE) || (state_reg == WAIT_CS);

endmodule

// File: tb/tb_t07_spitft_rx.sv
// Self-checking bench for t07_spitft_rx: table of frames plus hand-written
// sequences for overrun, same-cycle reload and mid-frame reset.
module tb_t07_spitft_rx;
  import t07_spi_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          nbits;
    int          exp_ferr;
    bit          deliver;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        chipSelect = 1'b1;
  logic        sclk = 1'b0;
  logic        bitData = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] address;
  logic [31:0] data;
  logic        valid;
  logic        busy;
  logic        frameErr;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int rd_idx = 0;
  int wait_n;
  int f0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  t07_spitft_rx dut (
    .clk       (clk),
    .nrst      (nrst),
    .chipSelect(chipSelect),
    .sclk      (sclk),
    .bitData   (bitData),
    .address   (address),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frameErr  (frameErr),
    .overrun   (overrun)
  );

  // Monitor: records every handshake and every frameErr cycle.
  always @(negedge clk) begin
    if (frameErr) ferr_cnt++;
    if (valid && ready) got_q.push_back({address, data});
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic sclk_bit(input logic b);
    sclk = 1'b0;
    bitData = b;
    tick(4);
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input logic [63:0] frame, input int nbits);
    chipSelect = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < 64) sclk_bit(frame[63-i]);
      else sclk_bit(1'($urandom_range(0, 1)));
    end
    sclk = 1'b0;
    tick(4);
    chipSelect = 1'b1;
    tick(8);
  endtask

  // Compare every observed transfer against the expected queue, in order.
  task automatic drain(input string tag);
    logic [63:0] e;
    while (rd_idx < got_q.size()) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_xfer actual=%h required=none", tag, got_q[rd_idx]);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_xfer"}, got_q[rd_idx], e);
      end
      rd_idx++;
    end
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{32'h7ABE01D5, 32'hA0BCAA3D, 64, 0, 1'b1};
    vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 40, 1, 1'b0};
    vecs[2] = '{32'h00000001, 32'hFFFFFFFF, 64, 0, 1'b1};
    vecs[3] = '{32'hC0FFEE00, 32'h0BADF00D, 70, 0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h00000001, 64, 0, 1'b1};
    vecs[5] = '{32'hDEADBEEF, 32'h01234567, 0,  0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1,  1, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 63, 1, 1'b0};
    vecs[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 64, 0, 1'b1};

    // Reset state
    tick(3);
    check("rst_address", 64'(address), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_flags", 64'({valid, busy, frameErr, overrun}), 64'd0);
    nrst = 1'b1;
    tick(6);
    check("idle_busy", 64'(busy), 64'd0);

    // Table-driven frames, ready held high
    ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      f0 = ferr_cnt;
      if (vecs[k].deliver) exp_q.push_back({vecs[k].addr, vecs[k].data});
      send_frame({vecs[k].addr, vecs[k].data}, vecs[k].nbits);
      tick(4);
      drain($sformatf("vec%0d", k));
      check($sformatf("vec%0d_ferr", k), 64'(ferr_cnt - f0), 64'(vecs[k].exp_ferr));
      check($sformatf("vec%0d_valid_ovr", k), 64'({valid, overrun}), 64'd0);
    end

    // Consumer handshake in the same cycle as DONE
    ready = 1'b0;
    exp_q.push_back({32'hCAFEF00D, 32'h13572468});
    send_frame({32'hCAFEF00D, 32'h13572468}, 64);
    check("hold_valid", 64'(valid), 64'd1);
    exp_q.push_back({32'h0F0F0F0F, 32'hF0F0F0F0});
    fork
      send_frame({32'h0F0F0F0F, 32'hF0F0F0F0}, 64);
      begin
        wait_n = 0;
        while (dut.state_reg != DONE && wait_n < 3000) begin
          tick(1);
          wait_n++;
        end
        check("done_seen", 64'(wait_n < 3000), 64'd1);
        ready = 1'b1;
        tick(1);
        check("same_cycle_valid", 64'(valid), 64'd1);
        check("same_cycle_pair", {address, data}, {32'h0F0F0F0F, 32'hF0F0F0F0});
      end
    join
    tick(4);
    drain("same_cycle");
    check("same_cycle_ovr", 64'(overrun), 64'd0);

    // Overrun: second frame dropped while the first is held
    ready = 1'b0;
    exp_q.push_back({32'h11111111, 32'h22222222});
    send_frame({32'h11111111, 32'h22222222}, 64);
    send_frame({32'h33333333, 32'h44444444}, 64);
    tick(4);
    check("ovr_held", {address, data}, {32'h11111111, 32'h22222222});
    check("ovr_flags", 64'({valid, overrun}), 64'b11);
    ready = 1'b1;
    tick(4);
    drain("ovr");
    check("ovr_after", 64'({valid, overrun}), 64'b01);

    // Reset pulsed mid-frame at bit 20
    f0 = ferr_cnt;
    chipSelect = 1'b0;
    tick(4);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        nrst = 1'b0;
        tick(2);
        check("midrst_state", 64'({valid, busy, overrun}), 64'd0);
        nrst = 1'b1;
      end
      sclk_bit(1'($urandom_range(0, 1)));
    end
    sclk = 1'b0;
    tick(4);
    chipSelect = 1'b1;
    tick(8);
    drain("midrst");
    check("midrst_ferr", 64'(ferr_cnt - f0), 64'd0);
    check("midrst_flags", 64'({valid, overrun}), 64'd0);
    exp_q.push_back({32'h2468ACE0, 32'h13579BDF});
    send_frame({32'h2468ACE0, 32'h13579BDF}, 64);
    tick(4);
    drain("post_rst");
    check("post_rst_ferr", 64'(ferr_cnt - f0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
